// File: rtl/cpu_cond_pkg.sv
// Shared definitions for the conditional-execution stage.
//   - Condition-code values (instruction bits [31:28]).
//   - Bit positions inside the {N,Z,C,V} flag vector.
//   - Bit positions inside the two-bit flag-write enable.
package cpu_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Condition evaluator: maps a 4-bit condition field and the stored
// {N,Z,C,V} flags to a pass/fail bit. Purely combinational.
// Ports:
//   cond    in  [3:0]  condition field
//   flags   in  [3:0]  stored {N,Z,C,V}
//   cond_ex out        1 when the condition holds
module cond_check
    import cpu_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flag register, evaluates the
// instruction condition against the stored flags and gates the control
// unit's write/PC requests so a failed condition turns the instruction
// into a no-op.
// Ports:
//   CLK         in         system clock, rising edge
//   RESET       in         asynchronous active-high reset
//   COND        in  [3:0]  condition field
//   ALU_FLAGS   in  [3:0]  {N,Z,C,V} from the ALU for this instruction
//   FLAG_WRITE  in  [1:0]  bit1 = update N/Z, bit0 = update C/V
//   NO_WRITE    in         suppress register write (compare ops)
//   PCS         in         PC write request
//   REG_W       in         register-file write request
//   MEM_W       in         data-memory write request
//   PC_SRC      out        gated PC source select
//   REG_WRITE   out        gated register-file write enable
//   MEM_WRITE   out        gated data-memory write enable
//   COND_EX     out        condition passed on stored flags
//   FLAGS       out [3:0]  stored {N,Z,C,V}
module cond_logic
    import cpu_cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COND,
    input  logic [3:0] ALU_FLAGS,
    input  logic [1:0] FLAG_WRITE,
    input  logic       NO_WRITE,
    input  logic       PCS,
    input  logic       REG_W,
    input  logic       MEM_W,
    output logic       PC_SRC,
    output logic       REG_WRITE,
    output logic       MEM_WRITE,
    output logic       COND_EX,
    output logic [3:0] FLAGS
);

    logic [1:0] nz;
    logic [1:0] cv;

    assign FLAGS = {nz, cv};

    // Evaluated on the stored flags only, so an instruction sees the flags
    // produced before it, never its own ALU result.
    cond_check u_cond_check (
        .cond    (COND),
        .flags   (FLAGS),
        .cond_ex (COND_EX)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nz <= RESET_FLAGS[FLAG_N:FLAG_Z];
            cv <= RESET_FLAGS[FLAG_C:FLAG_V];
        end else begin
            if (FLAG_WRITE[FW_NZ] && COND_EX) begin
                nz <= ALU_FLAGS[FLAG_N:FLAG_Z];
            end
            if (FLAG_WRITE[FW_CV] && COND_EX) begin
                cv <= ALU_FLAGS[FLAG_C:FLAG_V];
            end
        end
    end

    // Side-effecting enables are held off for the whole reset window.
    assign PC_SRC    = PCS   & COND_EX & ~RESET;
    assign REG_WRITE = REG_W & COND_EX & ~NO_WRITE & ~RESET;
    assign MEM_WRITE = MEM_W & COND_EX & ~RESET;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios, an exhaustive
// condition/flag sweep and randomized traffic compared against a
// behavioural model of the flag register and condition rules.
module tb_cond_logic;

    logic       CLK;
    logic       RESET;
    logic [3:0] COND;
    logic [3:0] ALU_FLAGS;
    logic [1:0] FLAG_WRITE;
    logic       NO_WRITE;
    logic       PCS;
    logic       REG_W;
    logic       MEM_W;
    logic       PC_SRC;
    logic       REG_WRITE;
    logic       MEM_WRITE;
    logic       COND_EX;
    logic [3:0] FLAGS;

    int n_checks;
    int n_pass;

    logic [3:0] m_flags;

    cond_logic dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .COND       (COND),
        .ALU_FLAGS  (ALU_FLAGS),
        .FLAG_WRITE (FLAG_WRITE),
        .NO_WRITE   (NO_WRITE),
        .PCS        (PCS),
        .REG_W      (REG_W),
        .MEM_W      (MEM_W),
        .PC_SRC     (PC_SRC),
        .REG_WRITE  (REG_WRITE),
        .MEM_WRITE  (MEM_WRITE),
        .COND_EX    (COND_EX),
        .FLAGS      (FLAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Conditions come in pairs: even code = predicate, odd code = its
    // inverse; 1110 is always, 1111 never.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        if (c == 4'b1110) return 1'b1;
        return c[0] ? !base : base;
    endfunction

    // One instruction: drive, check combinational outputs, clock, update model.
    task automatic step(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                        input logic nw, input logic p, input logic rw, input logic mw);
        logic ex;
        COND       = c;
        ALU_FLAGS  = a;
        FLAG_WRITE = fw;
        NO_WRITE   = nw;
        PCS        = p;
        REG_W      = rw;
        MEM_W      = mw;
        #1;
        ex = model_pass(c, m_flags);
        check("flags",     FLAGS,     m_flags);
        check("cond_ex",   COND_EX,   ex);
        check("pc_src",    PC_SRC,    p & ex);
        check("reg_write", REG_WRITE, rw & ex & !nw);
        check("mem_write", MEM_WRITE, mw & ex);
        @(posedge CLK);
        if (ex && fw[1]) m_flags[3:2] = a[3:2];
        if (ex && fw[0]) m_flags[1:0] = a[1:0];
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_flags  = 4'b0000;

        // Reset window: write request must be blocked, condition still live.
        RESET      = 1'b1;
        COND       = 4'b1110;
        ALU_FLAGS  = 4'b0000;
        FLAG_WRITE = 2'b00;
        NO_WRITE   = 1'b0;
        PCS        = 1'b0;
        REG_W      = 1'b1;
        MEM_W      = 1'b0;
        #2;
        check("rst_flags",     FLAGS,     4'b0000);
        check("rst_reg_write", REG_WRITE, 1'b0);
        check("rst_cond_ex",   COND_EX,   1'b1);
        #10;
        RESET = 1'b0;
        #1;
        check("post_rst_reg_write", REG_WRITE, 1'b1);
        @(posedge CLK);
        #1;

        // Set Z, then test EQ / NE.
        step(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("set_z", FLAGS, 4'b0100);
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        step(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);

        // Compare: no register write, flags still updated.
        step(4'b1110, 4'b1000, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        check("cmp_flags", FLAGS, 4'b1000);
        step(4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Partial N/Z-only update keeps C/V.
        step(4'b1110, 4'b0011, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b1110, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        check("partial_nz", FLAGS, 4'b0111);
        step(4'b1110, 4'b1010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        check("partial_cv", FLAGS, 4'b0110);

        // Failed condition blocks the flag write and the branch.
        step(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fail_no_update", FLAGS, 4'b0000);

        // Every condition against every flag state.
        for (int f = 0; f < 16; f++) begin
            step(4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                step(4'(c), 4'($urandom()), 2'b00, 1'($urandom()), 1'($urandom()),
                     1'($urandom()), 1'($urandom()));
            end
        end

        // Random traffic including flag writes under arbitrary conditions.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom()), 4'($urandom()), 2'($urandom()), 1'($urandom()),
                 1'($urandom()), 1'($urandom()), 1'($urandom()));
        end

        // Asynchronous reset in the middle of operation.
        step(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_flags", FLAGS, 4'b1111);
        COND       = 4'b1110;
        ALU_FLAGS  = 4'b1111;
        FLAG_WRITE = 2'b11;
        PCS        = 1'b1;
        REG_W      = 1'b1;
        MEM_W      = 1'b1;
        NO_WRITE   = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check("mid_rst_flags",     FLAGS,     4'b0000);
        check("mid_rst_pc_src",    PC_SRC,    1'b0);
        check("mid_rst_reg_write", REG_WRITE, 1'b0);
        check("mid_rst_mem_write", MEM_WRITE, 1'b0);
        @(posedge CLK);
        #2;
        check("rst_holds_flags", FLAGS, 4'b0000);
        RESET = 1'b0;
        m_flags = 4'b0000;
        @(posedge CLK);
        m_flags = 4'b1111;
        #1;
        check("first_edge_update", FLAGS, m_flags);
        step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
